ifetch_unit: RTL and testbench

- Instruction fetch front end that produces the (pc, instruction) pair consumed by the decode stage.
- Owns the fetch PC and issues in-order requests to instruction memory over a req/gnt/rvalid handshake with variable latency.
- Buffers returned words in a small queue and presents one instruction per cycle to decode through an output register.
- Supports downstream stall and branch/exception flush with redirect.

---
 rtl/ifetch_unit.sv | 150 +++++++++++++++
 tb/tb_ifetch_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues in-order imem requests
// under a credit limit, queues returned words and presents one (pc, inst) per cycle.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_BOOT, S_RUN} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]   in_flight_q, in_flight_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        inst_q, inst_d;
  logic               valid_q, valid_d;
  entry_t             fifo_q [BUF_DEPTH];

  logic [CNT_W:0]     credit_sum;
  logic               req, grant, resp, drop, accept, pop, bypass, push;

  // Handshake qualifiers; a response with nothing outstanding is ignored.
  always_comb begin
    credit_sum = {1'b0, in_flight_q} + {1'b0, count_q};
    req        = (state_q == S_RUN) && (credit_sum < (CNT_W+1)'(BUF_DEPTH));
    grant      = req && imem_gnt_i;
    resp       = imem_rvalid_i && (in_flight_q != '0);
    drop       = resp && (drop_cnt_q != '0);
    accept     = resp && !drop && !flush_i;
    pop        = !flush_i && !stall_i && (count_q != '0);
    bypass     = !flush_i && !stall_i && (count_q == '0) && accept;
    push       = accept && !bypass;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d     = S_RUN;
    fetch_pc_d  = fetch_pc_q;
    resp_pc_d   = resp_pc_q;
    in_flight_d = in_flight_q + CNT_W'(grant) - CNT_W'(resp);
    drop_cnt_d  = drop_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    valid_d     = valid_q;

    if (flush_i) begin
      // Everything still outstanding after this edge belongs to the old path.
      drop_cnt_d = in_flight_d;
      fetch_pc_d = flush_pc_i;
      resp_pc_d  = flush_pc_i;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      inst_d     = 32'h0;
      valid_d    = 1'b0;
    end else begin
      if (grant)  fetch_pc_d = fetch_pc_q + 32'd4;
      if (drop)   drop_cnt_d = drop_cnt_q - CNT_W'(1);
      if (accept) resp_pc_d  = resp_pc_q + 32'd4;
      if (push)   wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      if (!stall_i) begin
        if (pop) begin
          pc_d    = fifo_q[rd_ptr_q].pc;
          inst_d  = fifo_q[rd_ptr_q].inst;
          valid_d = 1'b1;
        end else if (bypass) begin
          pc_d    = resp_pc_q;
          inst_d  = imem_rdata_i;
          valid_d = 1'b1;
        end else begin
          inst_d  = 32'h0;
          valid_d = 1'b0;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_BOOT;
      fetch_pc_q  <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      in_flight_q <= '0;
      drop_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pc_q        <= 32'h0;
      inst_q      <= 32'h0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      in_flight_q <= in_flight_d;
      drop_cnt_q  <= drop_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      valid_q     <= valid_d;
    end
  end

  // NOTE: queue storage is not reset; count/pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{pc: resp_pc_q, inst: imem_rdata_i};
  end

  assign imem_req_o   = req;
  assign imem_addr_o  = fetch_pc_q;
  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a behavioural in-order instruction memory
// whose response enable can be gated to create variable latency.
module tb_ifetch_unit;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  logic        rv_en;
  logic [31:0] pending [$];
  int          checks   = 0;
  int          failures = 0;

  ifetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o)
  );

  always #5 clk = ~clk;

  // Memory: handshakes are observed mid-cycle, responses driven 3 time units after the edge.
  initial begin
    logic [31:0] a;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    forever begin
      @(negedge clk);
      if (rst && imem_req_o && imem_gnt_i) pending.push_back(imem_addr_o);
      @(posedge clk);
      #3;
      if (!rst) begin
        pending.delete();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
      end else if (rv_en && pending.size() > 0) begin
        a             = pending.pop_front();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = a ^ K;
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic out(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                     input logic valid);
    check({tag, "_pc"},    pc_o, pc);
    check({tag, "_inst"},  inst_o, inst);
    check({tag, "_valid"}, {31'h0, inst_valid_o}, {31'h0, valid});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; imem_gnt_i = 1'b1; rv_en = 1'b1;
    stall_i = 1'b0; flush_i = 1'b0; flush_pc_i = 32'h0;

    #2;
    out("reset", 32'h0, 32'h0, 1'b0);
    check("reset_req", {31'h0, imem_req_o}, 32'h0);
    step(); step();
    rst = 1'b1;
    check("boot_req", {31'h0, imem_req_o}, 32'h0);
    step();
    check("first_req", {31'h0, imem_req_o}, 32'h1);
    check("first_addr", imem_addr_o, 32'h0);
    step();
    check("pre_data_valid", {31'h0, inst_valid_o}, 32'h0);

    // Streaming with one-cycle memory latency
    step(); out("s0", 32'h0, K, 1'b1);
    step(); out("s4", 32'h4, 32'h4 ^ K, 1'b1);
    step(); out("s8", 32'h8, 32'h8 ^ K, 1'b1);

    // Stall: outputs hold, queue fills, requests stop
    stall_i = 1'b1;
    step(); out("stall1", 32'h8, 32'h8 ^ K, 1'b1);
    step(); out("stall2", 32'h8, 32'h8 ^ K, 1'b1);
    check("stall2_req", {31'h0, imem_req_o}, 32'h0);
    step(); out("stall3", 32'h8, 32'h8 ^ K, 1'b1);
    check("stall3_req", {31'h0, imem_req_o}, 32'h0);
    stall_i = 1'b0;
    step(); out("post12", 32'hC, 32'hC ^ K, 1'b1);
    step(); out("post16", 32'h10, 32'h10 ^ K, 1'b1);
    step(); out("post20", 32'h14, 32'h14 ^ K, 1'b1);

    // Grant withheld: address holds, output drains
    imem_gnt_i = 1'b0;
    step(); out("gl0", 32'h18, 32'h18 ^ K, 1'b1);
    check("gl0_addr", imem_addr_o, 32'h1C);
    for (int i = 0; i < 3; i++) begin
      step(); out("gl", 32'h18, 32'h0, 1'b0);
      check("gl_addr", imem_addr_o, 32'h1C);
      check("gl_req", {31'h0, imem_req_o}, 32'h1);
    end
    imem_gnt_i = 1'b1;
    step(); check("gl_end_valid", {31'h0, inst_valid_o}, 32'h0);
    step(); out("gl_resume", 32'h1C, 32'h1C ^ K, 1'b1);

    // Flush with 0x20 and 0x24 outstanding
    rv_en = 1'b0;
    step();
    check("two_inflight_req", {31'h0, imem_req_o}, 32'h0);
    flush_i = 1'b1; flush_pc_i = 32'h100;
    step();
    flush_i = 1'b0; rv_en = 1'b1;
    check("flush_inst", inst_o, 32'h0);
    check("flush_valid", {31'h0, inst_valid_o}, 32'h0);
    check("flush_addr", imem_addr_o, 32'h100);
    step(); check("drop1_valid", {31'h0, inst_valid_o}, 32'h0);
    step(); check("drop2_valid", {31'h0, inst_valid_o}, 32'h0);
    step(); out("redirect", 32'h100, 32'h100 ^ K, 1'b1);

    // Flush beats stall and a same-cycle response/grant
    stall_i = 1'b1; flush_i = 1'b1; flush_pc_i = 32'h200;
    step();
    stall_i = 1'b0; flush_i = 1'b0;
    check("fs_inst", inst_o, 32'h0);
    check("fs_valid", {31'h0, inst_valid_o}, 32'h0);
    check("fs_addr", imem_addr_o, 32'h200);
    step(); check("fs_drop_valid", {31'h0, inst_valid_o}, 32'h0);
    step(); out("fs_redirect", 32'h200, 32'h200 ^ K, 1'b1);

    // Async reset with two requests outstanding
    stall_i = 1'b1; rv_en = 1'b0;
    step(); out("pre_rst", 32'h200, 32'h200 ^ K, 1'b1);
    rst = 1'b0;
    #1;
    out("async_rst", 32'h0, 32'h0, 1'b0);
    check("async_rst_req", {31'h0, imem_req_o}, 32'h0);
    stall_i = 1'b0; rv_en = 1'b1;
    step(); step();
    rst = 1'b1;
    check("reboot_req", {31'h0, imem_req_o}, 32'h0);
    step();
    check("reboot_req1", {31'h0, imem_req_o}, 32'h1);
    check("reboot_addr", imem_addr_o, 32'h0);
    step(); step(); out("reboot_s0", 32'h0, K, 1'b1);

    // Fetch PC wraps past the top of the address space
    flush_i = 1'b1; flush_pc_i = 32'hFFFF_FFFC;
    step();
    flush_i = 1'b0;
    check("wrap_flush_valid", {31'h0, inst_valid_o}, 32'h0);
    step(); check("wrap_addr", imem_addr_o, 32'h0);
    step(); out("wrap_top", 32'hFFFF_FFFC, 32'h5A5A_FFFC, 1'b1);
    step(); out("wrap_zero", 32'h0, K, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
